// File: rtl/mux_n_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mux_n_pipe
// Brief    : N-input registered selector with valid/ready output stage and a
//            one-entry skid buffer. Optional macro MUX_N_PIPE_SELCHK_EN adds a
//            sticky out-of-range selector flag (sel_err).
// Revision : 1.0 - initial release
// ============================================================================
module mux_n_pipe #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        selector,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_N_PIPE_SELCHK_EN
    ,
    output logic                    sel_err
`endif
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] w_sel_word;
    logic             w_sel_oob;
    logic             w_accept;
    logic             w_drain;

    // Out-of-range selectors match no input, leaving the word at zero.
    always_comb begin
        w_sel_word = '0;
        w_sel_oob  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (selector == SEL_W'(k)) begin
                w_sel_word = in_data[k*WIDTH +: WIDTH];
                w_sel_oob  = 1'b0;
            end
        end
    end

    assign w_accept  = in_valid & in_ready;
    assign w_drain   = r_out_valid & out_ready;
    assign in_ready  = ~r_skid_valid;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid) begin
            if (w_accept) begin
                r_out_data  <= w_sel_word;
                r_out_valid <= 1'b1;
            end
        end else if (r_skid_valid) begin
            // Full: only a drain can happen, the skid word moves forward.
            if (w_drain) begin
                r_out_data   <= r_skid_data;
                r_skid_valid <= 1'b0;
            end
        end else begin
            if (w_accept && w_drain) begin
                r_out_data <= w_sel_word;
            end else if (w_accept) begin
                r_skid_data  <= w_sel_word;
                r_skid_valid <= 1'b1;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_N_PIPE_SELCHK_EN
    logic r_sel_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_sel_oob) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;
`else
    logic w_unused_oob;
    assign w_unused_oob = w_sel_oob;
`endif

endmodule
`default_nettype wire
